slot_alloc6: RTL and testbench



---
 rtl/slot_alloc6_pkg.sv | 20 ++
 rtl/slot_alloc6_if.sv | 28 ++
 rtl/slot_alloc6_ffo6.sv | 20 ++
 rtl/slot_alloc6.sv | 125 ++++++++++++
 tb/tb_slot_alloc6.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/slot_alloc6_pkg.sv
// Shared types and helpers for the six-entry slot allocator.
// Latency: n/a (types, constants and a combinational popcount only).
// Backpressure: n/a.
// Contents: slot_id_t (3-bit slot index), SLOT_NONE (encoder "no free slot"), popcnt6().
package slot_alloc6_pkg;

  typedef logic [2:0] slot_id_t;

  localparam slot_id_t SLOT_NONE = 3'd7;

  function automatic logic [2:0] popcnt6(input logic [5:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 6; i++) begin
      c = c + 3'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/slot_alloc6_if.sv
// Allocation / free / status bundle between slot_alloc6 and its clients.
// Latency: n/a (wires only).
// Backpressure: alloc_rdy_i stalls the offered slot; the free port has no backpressure.
// Ports: master = allocator side (drives alloc_v_o/alloc_id_o/free_map_o/free_cnt_o/err_o),
//        slave  = client side (drives alloc_rdy_i/free_v_i/free_id_i).
interface slot_alloc6_if;
  import slot_alloc6_pkg::*;

  logic       alloc_v_o;
  slot_id_t   alloc_id_o;
  logic       alloc_rdy_i;
  logic       free_v_i;
  slot_id_t   free_id_i;
  logic [5:0] free_map_o;
  logic [2:0] free_cnt_o;
  logic       err_o;

  modport master (
    output alloc_v_o, alloc_id_o, free_map_o, free_cnt_o, err_o,
    input  alloc_rdy_i, free_v_i, free_id_i
  );

  modport slave (
    input  alloc_v_o, alloc_id_o, free_map_o, free_cnt_o, err_o,
    output alloc_rdy_i, free_v_i, free_id_i
  );

endinterface

// File: rtl/slot_alloc6_ffo6.sv
// ffo6: find-first-one encoder over a 6-bit map, highest set index wins.
// Latency: combinational.
// Backpressure: n/a.
// Ports: vec (6-bit map in), idx (index of highest set bit, SLOT_NONE when vec is zero).
module ffo6
  import slot_alloc6_pkg::*;
(
  input  logic [5:0] vec,
  output slot_id_t   idx
);

  // Ascending scan: the last hit overwrites earlier ones, so the highest index wins.
  always_comb begin
    idx = SLOT_NONE;
    for (int i = 0; i < 6; i++) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/slot_alloc6.sv
// slot_alloc6: six-entry free-list manager; pre-loads the next free slot into a valid/ready output register.
// Latency: 1 cycle from reset release to first offer; a freed slot reappears 2 cycles later when the output is empty.
// Backpressure: alloc_rdy_i low holds alloc_id_o stable; frees are always taken (illegal ones set sticky err_o).
// Ports: clk_i, rst_ni (sync active-low), flush_i (sync clear-all), bus (slot_alloc6_if.master).
// Build option: SLOT_ALLOC_ROTATE_EN selects round-robin pick (descending, wrap-around) instead of highest-free-first.
module slot_alloc6
  import slot_alloc6_pkg::*;
#(
  parameter int NSLOT = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  slot_alloc6_if.master bus
);

  localparam logic [5:0] VALID_MASK = 6'((1 << NSLOT) - 1);
  localparam slot_id_t   NSLOT_ID   = 3'(NSLOT);
  localparam logic [2:0] NSLOT_CNT  = 3'(NSLOT);

  logic       alloc_v_q;
  slot_id_t   alloc_id_q;
  logic [5:0] map_q;
  logic [2:0] cnt_q;
  logic       err_q;

  slot_id_t   sel;
  logic       load;
  logic       free_ok;
  logic       free_bad;
  logic [7:0] map_ext;
  logic [7:0] free_oh;
  logic [7:0] sel_oh;
  logic [5:0] map_d;

`ifdef SLOT_ALLOC_ROTATE_EN
  slot_id_t   last_id_q;
  logic [5:0] below_mask;
  slot_id_t   sel_lo;
  slot_id_t   sel_all;

  // Slots strictly below the last loaded ID; last_id=7 covers every slot.
  always_comb begin
    below_mask = 6'd0;
    for (int i = 0; i < 6; i++) begin
      below_mask[i] = (3'(i) < last_id_q);
    end
  end

  ffo6 u_ffo_lo  (.vec(map_q & below_mask), .idx(sel_lo));
  ffo6 u_ffo_all (.vec(map_q),              .idx(sel_all));

  assign sel = (sel_lo != SLOT_NONE) ? sel_lo : sel_all;
`else
  ffo6 u_ffo (.vec(map_q), .idx(sel));
`endif

  assign load = !alloc_v_q || bus.alloc_rdy_i;

  // Zero-extended map so IDs 6/7 index a defined (always-0) bit.
  assign map_ext = {2'b00, map_q};
  assign free_oh = 8'd1 << bus.free_id_i;
  assign sel_oh  = 8'd1 << sel;

  // A held (offered but not yet consumed) slot is still owned by the allocator.
  always_comb begin
    free_ok  = 1'b0;
    free_bad = 1'b0;
    if (bus.free_v_i) begin
      if ((bus.free_id_i >= NSLOT_ID) || map_ext[bus.free_id_i] ||
          (alloc_v_q && (alloc_id_q == bus.free_id_i))) begin
        free_bad = 1'b1;
      end else begin
        free_ok = 1'b1;
      end
    end
  end

  // Pick uses map_q only, so a slot freed this cycle is not eligible until next cycle.
  always_comb begin
    map_d = map_q;
    if (load && (sel != SLOT_NONE)) map_d = map_d & ~sel_oh[5:0];
    if (free_ok)                    map_d = map_d | free_oh[5:0];
    map_d = map_d & VALID_MASK;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      alloc_v_q  <= 1'b0;
      alloc_id_q <= 3'd0;
      map_q      <= VALID_MASK;
      cnt_q      <= NSLOT_CNT;
      err_q      <= 1'b0;
    end else begin
      if (load) begin
        if (sel != SLOT_NONE) begin
          alloc_v_q  <= 1'b1;
          alloc_id_q <= sel;
        end else begin
          alloc_v_q  <= 1'b0;
        end
      end
      map_q <= map_d;
      cnt_q <= popcnt6(map_d);
      if (free_bad) err_q <= 1'b1;
    end
  end

`ifdef SLOT_ALLOC_ROTATE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      last_id_q <= SLOT_NONE;
    end else if (load && (sel != SLOT_NONE)) begin
      last_id_q <= sel;
    end
  end
`endif

  assign bus.alloc_v_o  = alloc_v_q;
  assign bus.alloc_id_o = alloc_id_q;
  assign bus.free_map_o = map_q;
  assign bus.free_cnt_o = cnt_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_slot_alloc6.sv
// Directed-vector bench for slot_alloc6 (default build, NSLOT=6).
// Each vector drives inputs for one cycle and checks the registered state after the edge.
// Ports: none (top-level bench).
module tb_slot_alloc6;
  import slot_alloc6_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;

  slot_alloc6_if sif ();

  slot_alloc6 #(.NSLOT(6)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       rdy;
    logic       fv;
    logic [2:0] fid;
    logic       e_v;
    logic [2:0] e_id;
    logic [5:0] e_map;
    logic [2:0] e_cnt;
    logic       e_err;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  int n_cmp;
  int n_bad;

  function automatic vec_t mk(input logic fl, input logic rdy, input logic fv, input logic [2:0] fid,
                              input logic ev, input logic [2:0] eid, input logic [5:0] emap,
                              input logic [2:0] ecnt, input logic eerr);
    vec_t v;
    v.flush = fl; v.rdy = rdy; v.fv = fv; v.fid = fid;
    v.e_v = ev; v.e_id = eid; v.e_map = emap; v.e_cnt = ecnt; v.e_err = eerr;
    return v;
  endfunction

  task automatic check_state(input string name, input logic ev, input logic [2:0] eid,
                             input logic [5:0] emap, input logic [2:0] ecnt, input logic eerr);
    n_cmp++;
    if (sif.alloc_v_o !== ev || sif.alloc_id_o !== eid || sif.free_map_o !== emap ||
        sif.free_cnt_o !== ecnt || sif.err_o !== eerr) begin
      n_bad++;
      $display("FAIL %s: got v=%b id=%0d map=%b cnt=%0d err=%b, want v=%b id=%0d map=%b cnt=%0d err=%b",
               name, sif.alloc_v_o, sif.alloc_id_o, sif.free_map_o, sif.free_cnt_o, sif.err_o,
               ev, eid, emap, ecnt, eerr);
    end
  endtask

  task automatic drive(input logic fl, input logic rdy, input logic fv, input logic [2:0] fid);
    flush = fl;
    sif.alloc_rdy_i = rdy;
    sif.free_v_i = fv;
    sif.free_id_i = fid;
  endtask

  logic [2:0] seen [$];
  logic [2:0] exp_seq [6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0);

    //                 fl rdy fv fid   v  id  map        cnt err
    vecs[0]  = mk(0, 1, 0, 0,    1, 5, 6'b011111, 5, 0);  // first offer 1 cycle after release
    vecs[1]  = mk(0, 1, 0, 0,    1, 4, 6'b001111, 4, 0);
    vecs[2]  = mk(0, 1, 0, 0,    1, 3, 6'b000111, 3, 0);
    vecs[3]  = mk(0, 1, 0, 0,    1, 2, 6'b000011, 2, 0);
    vecs[4]  = mk(0, 1, 0, 0,    1, 1, 6'b000001, 1, 0);
    vecs[5]  = mk(0, 1, 0, 0,    1, 0, 6'b000000, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0,    0, 0, 6'b000000, 0, 0);  // empty: valid drops
    vecs[7]  = mk(0, 0, 1, 3,    0, 0, 6'b001000, 1, 0);  // free 3 at t
    vecs[8]  = mk(0, 0, 0, 0,    1, 3, 6'b000000, 0, 0);  // 3 offered at t+2
    vecs[9]  = mk(0, 0, 0, 0,    1, 3, 6'b000000, 0, 0);  // stall holds
    vecs[10] = mk(0, 1, 1, 5,    0, 3, 6'b100000, 1, 0);  // accept 3, free 5
    vecs[11] = mk(0, 0, 1, 3,    1, 5, 6'b001000, 1, 0);  // same-cycle free 3 and load 5
    vecs[12] = mk(0, 0, 1, 5,    1, 5, 6'b001000, 1, 1);  // free of held slot is illegal
    vecs[13] = mk(1, 0, 1, 3,    0, 0, 6'b111111, 6, 0);  // flush beats free
    vecs[14] = mk(0, 0, 0, 0,    1, 5, 6'b011111, 5, 0);
    vecs[15] = mk(0, 0, 0, 0,    1, 5, 6'b011111, 5, 0);  // 4-cycle stall
    vecs[16] = mk(0, 0, 0, 0,    1, 5, 6'b011111, 5, 0);
    vecs[17] = mk(0, 0, 0, 0,    1, 5, 6'b011111, 5, 0);
    vecs[18] = mk(0, 0, 0, 0,    1, 5, 6'b011111, 5, 0);
    vecs[19] = mk(0, 0, 1, 2,    1, 5, 6'b011111, 5, 1);  // double free
    vecs[20] = mk(0, 0, 1, 6,    1, 5, 6'b011111, 5, 1);  // out-of-range free, err sticky
    vecs[21] = mk(0, 1, 0, 0,    1, 4, 6'b001111, 4, 1);
    vecs[22] = mk(0, 1, 0, 0,    1, 3, 6'b000111, 3, 1);
    vecs[23] = mk(1, 1, 1, 4,    0, 0, 6'b111111, 6, 0);  // flush with free pending
    vecs[24] = mk(0, 1, 0, 0,    1, 5, 6'b011111, 5, 0);  // 5 offered a cycle later

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 1'b0, 3'd0, 6'b111111, 3'd6, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].flush, vecs[i].rdy, vecs[i].fv, vecs[i].fid);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_id, vecs[i].e_map,
                  vecs[i].e_cnt, vecs[i].e_err);
      @(negedge clk);
    end

    // Drain with ready held high: every offered ID is recorded, bounded to 20 cycles.
    drive(1'b0, 1'b1, 1'b0, 3'd0);
    for (int c = 0; c < 20; c++) begin
      if (!sif.alloc_v_o) break;
      seen.push_back(sif.alloc_id_o);
      @(posedge clk);
      #1;
    end
    exp_seq[0] = 3'd5; exp_seq[1] = 3'd4; exp_seq[2] = 3'd3;
    exp_seq[3] = 3'd2; exp_seq[4] = 3'd1; exp_seq[5] = 3'd0;
    n_cmp++;
    if (seen.size() != 6) begin
      n_bad++;
      $display("FAIL drain_len: got %0d offers, want 6", seen.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (seen[i] !== exp_seq[i]) begin
          n_bad++;
          $display("FAIL drain_order[%0d]: got %0d, want %0d", i, seen[i], exp_seq[i]);
        end
      end
    end
    check_state("drained", 1'b0, 3'd0, 6'b000000, 3'd0, 1'b0);

    // Reset again mid-stream with a stalled offer outstanding.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 3'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_state("reset2", 1'b0, 3'd0, 6'b111111, 3'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
